// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state set, 25 MHz timing defaults,
// edge-count width and small helpers used by the line conditioning and the host TX.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAITIDLE
  } ps2_state_t;

  localparam int PS2_INHIBIT_CYC = 2500;    // 100 us
  localparam int PS2_RTS_CYC     = 25;
  localparam int PS2_TIMEOUT_CYC = 375000;  // 15 ms
  localparam int PS2_FILT_CYC    = 8;
  localparam int PS2_NW          = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // PS/2 frames carry odd parity: the bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioning: 2-flop synchronizers on clock and data, an optional clock
// glitch filter (PS2_HOST_TX_FILTER_EN) and a falling-edge pulse on the clock line.
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int FILT_CYC = PS2_FILT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2c_in,
  input  logic ps2d_in,
  output logic c_level,
  output logic c_fall,
  output logic d_level
);

`ifdef PS2_HOST_TX_FILTER_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif

  logic [1:0] pin;
  logic [1:0] sync_bit;
  logic       c_filt;
  logic       prev_reg;

  assign pin = {ps2d_in, ps2c_in};

  // Idle bus level is high, so synchronizers come out of reset at 1.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= pin[gi];
          sync_reg <= meta_reg;
        end
      end

      assign sync_bit[gi] = sync_reg;
    end
  endgenerate

  generate
    if (FILT_ON) begin : g_filt
      localparam int             FW    = $clog2(FILT_CYC + 1);
      localparam logic [FW-1:0]  FLAST = FW'(FILT_CYC - 1);
      localparam logic [FW-1:0]  FONE  = FW'(1);

      logic          filt_reg;
      logic [FW-1:0] fcnt_reg;

      // The filtered level follows only after FILT_CYC consecutive differing samples.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          filt_reg <= 1'b1;
          fcnt_reg <= '0;
        end else if (sync_bit[0] == filt_reg) begin
          fcnt_reg <= '0;
        end else if (fcnt_reg == FLAST) begin
          filt_reg <= sync_bit[0];
          fcnt_reg <= '0;
        end else begin
          fcnt_reg <= fcnt_reg + FONE;
        end
      end

      assign c_filt = filt_reg;
    end else begin : g_raw
      assign c_filt = sync_bit[0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_reg <= 1'b1;
    end else begin
      prev_reg <= c_filt;
    end
  end

  assign c_level = c_filt;
  assign c_fall  = prev_reg & ~c_filt;
  assign d_level = sync_bit[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain PS2C/PS2D enables.
// Optional clock glitch filter in the line conditioner: PS2_HOST_TX_FILTER_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = PS2_INHIBIT_CYC,
  parameter int RTS_CYC     = PS2_RTS_CYC,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC,
  parameter int FILT_CYC    = PS2_FILT_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       rdy,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe
);

  localparam int                CNT_MAX  = max3(INHIBIT_CYC, RTS_CYC, TIMEOUT_CYC);
  localparam int                CW       = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]     CNT_INH  = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0]     CNT_RTS  = CW'(RTS_CYC - 1);
  localparam logic [CW-1:0]     CNT_TMO  = CW'(TIMEOUT_CYC - 1);
  localparam logic [PS2_NW-1:0] N_ONE    = PS2_NW'(1);
  localparam logic [PS2_NW-1:0] N_PARITY = PS2_NW'(9);

  ps2_state_t        state_reg;
  logic [8:0]        shift_reg;
  logic [PS2_NW-1:0] n_reg;
  logic [CW-1:0]     cnt_reg;
  logic              nack_reg;

  logic c_level;
  logic c_fall;
  logic d_level;
  logic idle_now;
  logic tmo_state;
  logic tmo_hit;

  ps2_line_sync #(
    .FILT_CYC(FILT_CYC)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .ps2c_in(ps2c_in),
    .ps2d_in(ps2d_in),
    .c_level(c_level),
    .c_fall (c_fall),
    .d_level(d_level)
  );

  assign busy     = ~rdy;
  assign idle_now = c_level & d_level;

  // A device edge beats an expiring count; a bus already idle in WAITIDLE completes normally.
  assign tmo_state = (state_reg == SHIFT) || (state_reg == ACK) ||
                     ((state_reg == WAITIDLE) && !idle_now);
  assign tmo_hit   = tmo_state && !c_fall && (cnt_reg == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      rdy       <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      ps2c_oe   <= 1'b0;
      ps2d_oe   <= 1'b0;
      shift_reg <= '0;
      n_reg     <= '0;
      cnt_reg   <= '0;
      nack_reg  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tmo_hit) begin
        ps2c_oe   <= 1'b0;
        ps2d_oe   <= 1'b0;
        err       <= 1'b1;
        done      <= 1'b1;
        rdy       <= 1'b1;
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              shift_reg <= {odd_parity(data), data};
              err       <= 1'b0;
              nack_reg  <= 1'b0;
              rdy       <= 1'b0;
              ps2c_oe   <= 1'b1;
              cnt_reg   <= CNT_INH;
              state_reg <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (cnt_reg == '0) begin
              ps2d_oe   <= 1'b1;
              cnt_reg   <= CNT_RTS;
              state_reg <= RTS;
            end else begin
              cnt_reg <= cnt_reg - CNT_ONE;
            end
          end
          RTS: begin
            if (cnt_reg == '0) begin
              ps2c_oe   <= 1'b0;
              n_reg     <= '0;
              cnt_reg   <= CNT_TMO;
              state_reg <= SHIFT;
            end else begin
              cnt_reg <= cnt_reg - CNT_ONE;
            end
          end
          SHIFT: begin
            // Ones refill from the top, so the tenth edge drives the released stop bit.
            if (c_fall) begin
              cnt_reg   <= CNT_TMO;
              n_reg     <= n_reg + N_ONE;
              ps2d_oe   <= ~shift_reg[0];
              shift_reg <= {1'b1, shift_reg[8:1]};
              if (n_reg == N_PARITY) begin
                state_reg <= ACK;
              end
            end else begin
              cnt_reg <= cnt_reg - CNT_ONE;
            end
          end
          ACK: begin
            if (c_fall) begin
              nack_reg  <= d_level;
              cnt_reg   <= CNT_TMO;
              state_reg <= WAITIDLE;
            end else begin
              cnt_reg <= cnt_reg - CNT_ONE;
            end
          end
          WAITIDLE: begin
            if (idle_now) begin
              done      <= 1'b1;
              err       <= nack_reg;
              rdy       <= 1'b1;
              state_reg <= IDLE;
            end else if (c_fall) begin
              cnt_reg <= CNT_TMO;
            end else begin
              cnt_reg <= cnt_reg - CNT_ONE;
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model clocks the frame out and
// ACKs or NACKs; observed frames are compared with a byte-level frame model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 2500;
  localparam int RTSC = 25;
  localparam int TMO  = 3000;
  localparam int FILT = 8;
  localparam int HALF = 20;
`ifdef PS2_HOST_TX_FILTER_EN
  localparam int LAT = 3 + FILT;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       rdy, busy, done, err, ps2c_oe, ps2d_oe;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;
  logic       ps2c_line, ps2d_line;

  int n_cmp = 0;
  int n_bad = 0;

  assign ps2c_line = dev_c & ~ps2c_oe;
  assign ps2d_line = dev_d & ~ps2d_oe;

  ps2_host_tx #(
    .INHIBIT_CYC(INH),
    .RTS_CYC    (RTSC),
    .TIMEOUT_CYC(TMO),
    .FILT_CYC   (FILT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .data   (data),
    .rdy    (rdy),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .ps2c_in(ps2c_line),
    .ps2d_in(ps2d_line),
    .ps2c_oe(ps2c_oe),
    .ps2d_oe(ps2d_oe)
  );

  always #20 clk = ~clk;

  // Expected line levels: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic issue(input logic [7:0] b);
    @(negedge clk);
    start = 1'b1;
    data  = b;
    @(negedge clk);
    start = 1'b0;
    data  = 8'($urandom);
  endtask

  task automatic wait_release(output bit ok);
    int k;
    k = 0;
    while (ps2c_oe !== 1'b0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    ok = (ps2c_oe === 1'b0);
  endtask

  task automatic device_xfer(input bit nack, output logic [10:0] bits, output int lat,
                             output bit ok);
    bits = '0;
    lat  = 0;
    wait_release(ok);
    if (!ok) return;
    repeat (HALF) @(negedge clk);
    bits[0] = ps2d_line;
    for (int i = 1; i <= 10; i++) begin
      dev_c = 1'b0;
      for (int j = 1; j <= HALF; j++) begin
        @(negedge clk);
        if (i == 1 && lat == 0 && ps2d_oe === 1'b0) lat = j;
      end
      dev_c   = 1'b1;
      bits[i] = ps2d_line;
      repeat (HALF) @(negedge clk);
    end
    dev_d = nack;
    repeat (4) @(negedge clk);
    dev_c = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_c = 1'b1;
    dev_d = 1'b1;
  endtask

  task automatic wait_done(input int limit, output int cyc, output bit seen, output logic err_d);
    cyc   = 0;
    seen  = 1'b0;
    err_d = 1'bx;
    while (!seen && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        seen  = 1'b1;
        err_d = err;
      end
    end
  endtask

  task automatic xfer(input logic [7:0] b, input bit nack, output logic [10:0] bits,
                      output int lat, output bit seen, output logic err_d,
                      output logic done_after);
    bit ok;
    int cyc;
    issue(b);
    device_xfer(nack, bits, lat, ok);
    wait_done(200, cyc, seen, err_d);
    @(negedge clk);
    done_after = done;
    $display("xfer data=%h nack=%0b frame=%b done_seen=%0b err=%b", b, nack, bits, seen, err_d);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rdy, busy, done, err, ps2c_oe, ps2d_oe} !== 6'b100000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 100000", {rdy, busy, done, err, ps2c_oe, ps2d_oe});
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rdy, busy, ps2c_oe} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_release: got %b want 100", {rdy, busy, ps2c_oe});
    end
  endtask

  task automatic test_send_ed();
    int         inh, rts, lat, cyc;
    bit         ok, seen;
    logic [10:0] bits;
    logic       err_d, rdy_d;
    issue(8'hED);
    n_cmp++;
    if ({busy, err} !== 2'b10) begin
      n_bad++;
      $display("FAIL ed_accept: got busy,err=%b want 10", {busy, err});
    end
    inh = 0;
    while (ps2c_oe === 1'b1 && ps2d_oe === 1'b0 && inh < 5000) begin
      inh++;
      @(negedge clk);
    end
    rts = 0;
    while (ps2c_oe === 1'b1 && ps2d_oe === 1'b1 && rts < 100) begin
      rts++;
      @(negedge clk);
    end
    n_cmp++;
    if (inh != INH) begin
      n_bad++;
      $display("FAIL ed_inhibit_len: got %0d want %0d", inh, INH);
    end
    n_cmp++;
    if (rts != RTSC) begin
      n_bad++;
      $display("FAIL ed_rts_len: got %0d want %0d", rts, RTSC);
    end
    n_cmp++;
    if ({ps2c_oe, ps2d_oe} !== 2'b01) begin
      n_bad++;
      $display("FAIL ed_clock_release: got %b want 01", {ps2c_oe, ps2d_oe});
    end
    device_xfer(1'b0, bits, lat, ok);
    n_cmp++;
    if (bits !== frame(8'hED) || !ok) begin
      n_bad++;
      $display("FAIL ed_frame: got %b want %b", bits, frame(8'hED));
    end
    n_cmp++;
    if (lat != LAT) begin
      n_bad++;
      $display("FAIL ed_edge_latency: got %0d want %0d", lat, LAT);
    end
    wait_done(200, cyc, seen, err_d);
    rdy_d = rdy;
    n_cmp++;
    if (!seen || err_d !== 1'b0 || rdy_d !== 1'b1) begin
      n_bad++;
      $display("FAIL ed_done: got seen=%0b err=%b rdy=%b want 1 0 1", seen, err_d, rdy_d);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL ed_done_pulse: got %b want 0", done);
    end
    $display("xfer data=ed nack=0 frame=%b inhibit=%0d rts=%0d lat=%0d", bits, inh, rts, lat);
  endtask

  task automatic test_parity();
    logic [7:0]  pat [2];
    logic [10:0] bits, want;
    int          lat;
    bit          seen;
    logic        err_d, da;
    pat[0] = 8'h00;
    pat[1] = 8'h01;
    for (int i = 0; i < 2; i++) begin
      xfer(pat[i], 1'b0, bits, lat, seen, err_d, da);
      want = frame(pat[i]);
      n_cmp++;
      if (bits[9] !== want[9]) begin
        n_bad++;
        $display("FAIL parity_%h: got %b want %b", pat[i], bits[9], want[9]);
      end
      n_cmp++;
      if (bits !== want || !seen || err_d !== 1'b0) begin
        n_bad++;
        $display("FAIL parity_frame_%h: got %b err=%b want %b err=0", pat[i], bits, err_d, want);
      end
    end
  endtask

  task automatic test_nack();
    logic [7:0]  b;
    logic [10:0] bits;
    int          lat, cyc;
    bit          seen, ok;
    logic        err_d, da;
    b = 8'($urandom);
    xfer(b, 1'b1, bits, lat, seen, err_d, da);
    n_cmp++;
    if (!seen || err_d !== 1'b1 || da !== 1'b0) begin
      n_bad++;
      $display("FAIL nack_done: got seen=%0b err=%b done_after=%b want 1 1 0", seen, err_d, da);
    end
    repeat (50) @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL nack_err_held: got %b want 1", err);
    end
    b = 8'($urandom);
    issue(b);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL nack_err_clear: got %b want 0", err);
    end
    device_xfer(1'b0, bits, lat, ok);
    wait_done(200, cyc, seen, err_d);
    n_cmp++;
    if (bits !== frame(b) || !seen || err_d !== 1'b0) begin
      n_bad++;
      $display("FAIL nack_followup: got %b err=%b want %b err=0", bits, err_d, frame(b));
    end
    $display("xfer data=%h nack=0 frame=%b after nack", b, bits);
  endtask

  task automatic test_timeout();
    int   cyc;
    bit   ok, seen;
    logic err_d;
    logic [2:0] st;
    issue(8'($urandom));
    wait_release(ok);
    wait_done(TMO + 100, cyc, seen, err_d);
    st = {ps2c_oe, ps2d_oe, rdy};
    n_cmp++;
    if (!ok || !seen || cyc != TMO) begin
      n_bad++;
      $display("FAIL timeout_len: got %0d seen=%0b want %0d", cyc, seen, TMO);
    end
    n_cmp++;
    if (err_d !== 1'b1 || st !== 3'b001) begin
      n_bad++;
      $display("FAIL timeout_state: got err=%b oe_c,oe_d,rdy=%b want 1 001", err_d, st);
    end
    $display("xfer timeout after %0d cycles err=%b", cyc, err_d);
  endtask

  task automatic test_reset_mid();
    bit ok;
    issue(8'($urandom) & 8'hEF);
    wait_release(ok);
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dev_c = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_c = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_c = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (ps2d_oe !== 1'b1 || !ok) begin
      n_bad++;
      $display("FAIL midreset_bit5: got %b want 1", ps2d_oe);
    end
    #5 rst = 1'b0;
    #1;
    n_cmp++;
    if ({ps2c_oe, ps2d_oe, rdy, busy} !== 4'b0010) begin
      n_bad++;
      $display("FAIL midreset_release: got %b want 0010", {ps2c_oe, ps2d_oe, rdy, busy});
    end
    dev_c = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    $display("xfer reset at n=5, lines released");
  endtask

  task automatic test_busy_ignore();
    logic [7:0]  b;
    logic [10:0] bits;
    int          lat, cyc;
    bit          ok, seen;
    logic        err_d;
    b = 8'($urandom);
    if (b == 8'h55) b = 8'hAA;
    issue(b);
    repeat (100) @(negedge clk);
    n_cmp++;
    if (rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_rdy: got %b want 0", rdy);
    end
    start = 1'b1;
    data  = 8'h55;
    @(negedge clk);
    start = 1'b0;
    device_xfer(1'b0, bits, lat, ok);
    wait_done(200, cyc, seen, err_d);
    n_cmp++;
    if (bits !== frame(b) || !seen || err_d !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_ignore: got %b err=%b want %b err=0", bits, err_d, frame(b));
    end
    $display("xfer data=%h frame=%b with ignored start 55", b, bits);
  endtask

  task automatic test_random();
    logic [7:0]  b;
    bit          nack;
    logic [10:0] bits;
    int          lat;
    bit          seen;
    logic        err_d, da;
    for (int i = 0; i < 4; i++) begin
      b    = 8'($urandom);
      nack = ($urandom_range(0, 2) == 0);
      xfer(b, nack, bits, lat, seen, err_d, da);
      n_cmp++;
      if (bits !== frame(b) || !seen || err_d !== nack || da !== 1'b0) begin
        n_bad++;
        $display("FAIL random_%0d: got %b err=%b want %b err=%b", i, bits, err_d, frame(b), nack);
      end
    end
  endtask

`ifdef PS2_HOST_TX_FILTER_EN
  task automatic test_glitch();
    logic [7:0]  b;
    logic [10:0] bits;
    int          lat, cyc;
    bit          ok, seen;
    logic        err_d;
    b = 8'($urandom) | 8'h01;
    issue(b);
    wait_release(ok);
    dev_c = 1'b0;
    repeat (3) @(negedge clk);
    dev_c = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (ps2d_oe !== 1'b1 || !ok) begin
      n_bad++;
      $display("FAIL glitch_no_advance: got %b want 1", ps2d_oe);
    end
    device_xfer(1'b0, bits, lat, ok);
    wait_done(200, cyc, seen, err_d);
    n_cmp++;
    if (bits !== frame(b) || lat != LAT || !seen) begin
      n_bad++;
      $display("FAIL glitch_frame: got %b lat=%0d want %b lat=%0d", bits, lat, frame(b), LAT);
    end
    $display("xfer data=%h frame=%b after 3-cycle glitch", b, bits);
  endtask
`endif

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_send_ed();
    test_parity();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_busy_ignore();
    test_random();
`ifdef PS2_HOST_TX_FILTER_EN
    test_glitch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
